grid_readout: RTL
=================

# grid_readout

Downstream stage of the sudoku solver grid. Once the grid reports completion, this block snapshots the grid's row-major one-hot tile values. It then streams them out one tile per beat as binary digits over a valid/ready handshake, for a display or UART formatter. If the grid reports failure, it raises a sticky failure flag instead and streams nothing.

## Interface
- GRID_ORD, default 3: grid order; GRID_LEN = GRID_ORD², GRID_AREA = GRID_LEN², DIGIT_W = $clog2(GRID_LEN+1), IDX_W = $clog2(GRID_AREA)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- done_success  in  1  level from grid; solved
- done_failure  in  1  level from grid; unsolvable
- values  in  GRID_AREA*GRID_LEN  row-major tile values; tile i occupies bits [i*GRID_LEN +: GRID_LEN]; bit v set means digit v+1
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_digit  out  DIGIT_W  binary digit 1..GRID_LEN; 0 for empty or malformed tile
- out_index  out  IDX_W  row-major tile index of the current beat
- out_last  out  1  high on beat GRID_AREA-1
- busy  out  1  snapshot held / streaming in progress
- failed  out  1  grid reported failure
- bad_tile  out  1  sticky; some streamed tile was not exactly one-hot

## Operation
- States: IDLE, STREAM, DONE_OK, DONE_FAIL.
- IDLE
  - done_failure high → DONE_FAIL. Failure wins over a simultaneous done_success.
  - Otherwise, done_success high → snapshot <= values, idx <= 0, bad_tile <= 0, → STREAM.
- STREAM
  - out_valid = 1; out_index = idx; out_digit = decode(snapshot tile idx); out_last = (idx == GRID_AREA-1).
  - On out_valid & out_ready: if idx == GRID_AREA-1 → DONE_OK, else idx <= idx+1.
- decode
  - Exactly one bit v set → v+1.
  - Zero bits set → 0.
  - More than one bit set → 0, and set bad_tile on that beat's handshake.
- DONE_OK / DONE_FAIL: hold. When done_success and done_failure are both low (grid re-reset) → IDLE. A level that stays high never causes a replay.
- Output decodes:
  - busy = (state == STREAM).
  - failed = (state == DONE_FAIL).
  - bad_tile is a register, cleared only on capture or reset.
- The snapshot is isolated from `values` after capture; later changes to `values` do not affect the stream.

## Timing
- Reset values: state IDLE, out_valid 0, out_digit 0, out_index 0, out_last 0, busy 0, failed 0, bad_tile 0, idx 0.
- Latency: done_success sampled high in IDLE at edge n → out_valid high, beat 0, after edge n.
- Handshake:
  - Transfer occurs on any edge with out_valid & out_ready.
  - While out_valid is high and out_ready is low, out_digit, out_index and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Throughput: one beat per cycle with out_ready held high; a full grid takes GRID_AREA cycles.
- After the last transfer, out_valid is low on the next cycle.
- Reset asserted mid-stream: outputs clear immediately (asynchronous). After release the block sits in IDLE and restarts only on a fresh done_success level.
- idx never wraps; its range is 0..GRID_AREA-1.

## Structure
- Package sudoku_pkg holds:
  - GRID_ORD, GRID_LEN, GRID_AREA, DIGIT_W, IDX_W;
  - the readout_state_t enum, one-hot encoded like the grid FSM.
- Sub-module onehot_decode, combinational, GRID_LEN-bit input: outputs digit[DIGIT_W] and malformed.
- Tile select: an indexed part-select of the snapshot register at idx.
- Snapshot register width: GRID_AREA*GRID_LEN (729 bits at order 3).

## Test plan
- Solved 9×9 grid, values = a known valid solution, done_success pulse, out_ready = 1 → 81 consecutive beats, digits match the solution, out_index 0..80, out_last only on beat 80, then DONE_OK.
- Backpressure: toggle out_ready 1 cycle on / 2 off → every beat is held stable while stalled, no beat dropped or duplicated, still exactly 81 transfers.
- done_failure = 1 with done_success = 0, and separately both = 1 in the same cycle → failed = 1, out_valid never asserts.
- Tile 40 = 9'b000010010, tile 41 = 0 → beat 40 digit 0 with bad_tile set after its handshake; beat 41 digit 0 with bad_tile unchanged.
- Reset driven low at beat 30 → out_valid drops with no clock edge. After release with done_success still high, the stream restarts at index 0 (state IDLE, level sampled).
- After DONE_OK, hold done_success high for 10 cycles → no new stream. Drop it → IDLE; raise it → new capture and stream of the new values.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared sizing and state types for the sudoku solver grid and its readout.
// Grid order drives every derived width below.
package sudoku_pkg;

  localparam int GRID_ORD  = 3;
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;
  localparam int DIGIT_W   = $clog2(GRID_LEN + 1);
  localparam int IDX_W     = $clog2(GRID_AREA);
  localparam int VAL_W     = GRID_AREA * GRID_LEN;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    STREAM    = 4'b0010,
    DONE_OK   = 4'b0100,
    DONE_FAIL = 4'b1000
  } readout_state_t;

endpackage

// File: rtl/grid_readout_onehot_decode.sv
// One-hot tile to binary digit; empty or multi-hot tiles map to zero.
// Multi-hot tiles additionally raise malformed.
module onehot_decode
  import sudoku_pkg::*;
(
  input  logic [GRID_LEN-1:0] tile,
  output logic [DIGIT_W-1:0]  digit,
  output logic                malformed
);

  logic [DIGIT_W-1:0] pos;

  always_comb begin
    pos = '0;
    for (int v = 0; v < GRID_LEN; v++) begin
      if (tile[v]) pos = DIGIT_W'(v + 1);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign malformed = |(tile & (tile - GRID_LEN'(1)));
  assign digit     = malformed ? '0 : pos;

endmodule

// File: rtl/grid_readout.sv
// Snapshots the solved grid and streams one decoded tile per beat.
// A failed solve parks in DONE_FAIL and streams nothing.
module grid_readout
  import sudoku_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               done_success,
  input  logic               done_failure,
  input  logic [VAL_W-1:0]   values,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               busy,
  output logic               failed,
  output logic               bad_tile
);

  readout_state_t     state;
  logic [VAL_W-1:0]   snapshot;
  logic [IDX_W-1:0]   idx;
  logic [GRID_LEN-1:0] tile;
  logic [DIGIT_W-1:0] digit;
  logic               malformed;
  logic               at_last;

  assign tile    = snapshot[idx*GRID_LEN +: GRID_LEN];
  assign at_last = (idx == IDX_W'(GRID_AREA - 1));

  onehot_decode u_dec (
    .tile      (tile),
    .digit     (digit),
    .malformed (malformed)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snapshot <= '0;
      idx      <= '0;
      bad_tile <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (done_failure) begin
            state <= DONE_FAIL;
          end else if (done_success) begin
            snapshot <= values;
            idx      <= '0;
            bad_tile <= 1'b0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (malformed) bad_tile <= 1'b1;
            if (at_last) state <= DONE_OK;
            else         idx   <= idx + 1'b1;
          end
        end
        DONE_OK, DONE_FAIL: begin
          // Only a grid re-reset (both levels low) re-arms capture.
          if (!done_success && !done_failure) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == STREAM);
  assign failed    = (state == DONE_FAIL);
  assign out_valid = busy;
  assign out_index = busy ? idx : '0;
  assign out_digit = busy ? digit : '0;
  assign out_last  = busy & at_last;

endmodule
